// File: rtl/multicycle_compare.sv
// Chunk-serial magnitude comparator: scans operands MSB chunk first and stops at the
// first differing chunk, reporting signed/unsigned less-than and equality.
module multicycle_compare #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_less_s,
    output logic             o_less_u,
    output logic             o_equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sign_diff_q, sign_diff_d;
    logic               less_s_q, less_s_d;
    logic               less_u_q, less_u_d;
    logic               equal_q, equal_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic               chunk_lt;

    // Chunk mux with constant slice bounds keeps the select width-clean.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_lt = (a_chunk < b_chunk);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_diff_d = sign_diff_q;
        less_s_d    = less_s_q;
        less_u_d    = less_u_q;
        equal_d     = equal_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d         = i_a;
                    b_d         = i_b;
                    idx_d       = IDX_W'(NCHUNK - 1);
                    sign_diff_d = i_a[WIDTH-1] ^ i_b[WIDTH-1];
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (a_chunk != b_chunk) begin
                    // With differing signs the MSB chunk always differs, so A's sign decides.
                    equal_d  = 1'b0;
                    less_u_d = chunk_lt;
                    less_s_d = sign_diff_q ? a_q[WIDTH-1] : chunk_lt;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    equal_d  = 1'b1;
                    less_u_d = 1'b0;
                    less_s_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_diff_q <= 1'b0;
            less_s_q    <= 1'b0;
            less_u_q    <= 1'b0;
            equal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_diff_q <= sign_diff_d;
            less_s_q    <= less_s_d;
            less_u_q    <= less_u_d;
            equal_q     <= equal_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_less_s = less_s_q;
    assign o_less_u = less_u_q;
    assign o_equal  = equal_q;

endmodule

// File: tb/tb_multicycle_compare.sv
// Scoreboard bench for multicycle_compare: 32/8 instance with directed and random
// traffic, plus a 16/4 instance for the narrow configuration.
module tb_multicycle_compare;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int NC = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic         o_valid;
    logic         i_ready;
    logic         ls, lu, eq;
    logic [W-1:0] a, b;

    logic         dir_rdy;
    logic         rnd_rdy = 1'b1;
    logic         rand_mode;
    assign i_ready = rand_mode ? rnd_rdy : dir_rdy;

    multicycle_compare #(.WIDTH(W), .CHUNK(C)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (a),
        .i_b     (b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_less_s(ls),
        .o_less_u(lu),
        .o_equal (eq)
    );

    logic        rst2, v2, ordy2, ov2, ir2, ls2, lu2, eq2;
    logic [15:0] a2, b2;
    bit          done2 = 1'b0;

    multicycle_compare #(.WIDTH(16), .CHUNK(4)) dut16 (
        .i_clk   (clk),
        .i_reset (rst2),
        .i_valid (v2),
        .o_ready (ordy2),
        .i_a     (a2),
        .i_b     (b2),
        .o_valid (ov2),
        .i_ready (ir2),
        .o_less_s(ls2),
        .o_less_u(lu2),
        .o_equal (eq2)
    );

    typedef struct {
        logic ls;
        logic lu;
        logic eq;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // c0 is the cycle count sampled just before the accept edge.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c0);
        exp_t e;
        int   k;
        logic [W-1:0] d;
        e.eq = (x == y);
        e.lu = (x < y);
        e.ls = ($signed(x) < $signed(y));
        d = x ^ y;
        k = NC;
        for (int i = NC - 1; i >= 0; i--) begin
            if ((d >> (W - (i + 1) * C)) != '0) k = i + 1;
        end
        e.cyc = c0 + 1 + k;
        return e;
    endfunction

    // Monitor: new result on rising o_valid, stability checks while held.
    initial begin
        logic prev_v;
        exp_t cur;
        prev_v = 1'b0;
        cur = '{ls: 1'b0, lu: 1'b0, eq: 1'b0, cyc: 0};
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: o_valid=1 with no pending pair, required 0");
                    end else begin
                        cur = sb.pop_front();
                        chki("latency_cycle", cyc, cur.cyc);
                        chkb("less_s", ls, cur.ls);
                        chkb("less_u", lu, cur.lu);
                        chkb("equal", eq, cur.eq);
                    end
                end else begin
                    chkb("hold_less_s", ls, cur.ls);
                    chkb("hold_less_u", lu, cur.lu);
                    chkb("hold_equal", eq, cur.eq);
                end
            end
            prev_v = o_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: o_ready=%0b required 1", o_ready);
            return;
        end
        i_valid = 1'b1;
        a = x;
        b = y;
        if (track) sb.push_back(model(x, y, cyc));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] x, y;
        logic [C-1:0] r;
        rst = 1'b1;
        i_valid = 1'b0;
        a = '0;
        b = '0;
        dir_rdy = 1'b1;
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkb("rst_ready", o_ready, 1'b1);
        chkb("rst_valid", o_valid, 1'b0);
        chkb("rst_less_s", ls, 1'b0);
        chkb("rst_less_u", lu, 1'b0);
        chkb("rst_equal", eq, 1'b0);
        rst = 1'b0;

        send(32'h12345678, 32'h12345678, 1'b1); drain();
        send(32'h80000000, 32'h00000001, 1'b1); drain();
        send(32'h00000005, 32'h00000007, 1'b1); drain();
        send(32'h00FF0000, 32'h00FE0000, 1'b1); drain();

        // Backpressure with new operands offered while the result is held.
        dir_rdy = 1'b0;
        send(32'h00001111, 32'h00002222, 1'b1);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("bp_valid_seen", o_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            chkb("bp_ready_low", o_ready, 1'b0);
            chkb("bp_valid_high", o_valid, 1'b1);
            @(negedge clk);
        end
        dir_rdy = 1'b1;
        a = 32'h00000010;
        b = 32'h7FFFFFFF;
        @(posedge clk);
        @(negedge clk);
        chkb("bp_idle_ready", o_ready, 1'b1);
        chkb("bp_idle_valid", o_valid, 1'b0);
        sb.push_back(model(32'h00000010, 32'h7FFFFFFF, cyc));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        drain();

        // Reset during SCAN discards the pair.
        send(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chkb("midrst_ready", o_ready, 1'b1);
        chkb("midrst_valid", o_valid, 1'b0);
        chkb("midrst_less_s", ls, 1'b0);
        chkb("midrst_less_u", lu, 1'b0);
        chkb("midrst_equal", eq, 1'b0);
        repeat (10) @(negedge clk);

        // Random traffic with random consumer backpressure.
        rand_mode = 1'b1;
        for (int t = 0; t < 60; t++) begin
            x = $urandom;
            y = x;
            for (int j = 0; j < NC; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = C'($urandom);
                    y[j*C +: C] = r;
                end
            end
            if ($urandom_range(0, 5) == 0) y = $urandom;
            if ($urandom_range(0, 5) == 0) y[W-1] = ~y[W-1];
            send(x, y, 1'b1);
        end
        drain();

        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done2) begin
            checks++;
            errors++;
            $display("FAIL w16_timeout: done=%0b required 1", done2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Narrow configuration: 16-bit operands in 4-bit chunks.
    initial begin
        rst2 = 1'b1;
        v2 = 1'b0;
        a2 = '0;
        b2 = '0;
        ir2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        v2 = 1'b1;
        a2 = 16'hFFFF;
        b2 = 16'h0001;
        @(negedge clk);
        v2 = 1'b0;
        chkb("w16_scan_valid", ov2, 1'b0);
        @(negedge clk);
        chkb("w16_k1_valid", ov2, 1'b1);
        chkb("w16_k1_less_s", ls2, 1'b1);
        chkb("w16_k1_less_u", lu2, 1'b0);
        chkb("w16_k1_equal", eq2, 1'b0);
        @(negedge clk);
        chkb("w16_idle_ready", ordy2, 1'b1);
        v2 = 1'b1;
        a2 = 16'h1234;
        b2 = 16'h1243;
        @(negedge clk);
        v2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chkb("w16_k3_wait", ov2, 1'b0);
            @(negedge clk);
        end
        chkb("w16_k3_valid", ov2, 1'b1);
        chkb("w16_k3_less_s", ls2, 1'b1);
        chkb("w16_k3_less_u", lu2, 1'b1);
        chkb("w16_k3_equal", eq2, 1'b0);
        done2 = 1'b1;
    end

endmodule

// File: doc/multicycle_compare.md
MULTICYCLE_COMPARE -- requirements
Module: multicycle_compare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits compared per cycle; WIDTH % CHUNK == 0 is required, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port i_clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, width 1: operand pair i_a/i_b is valid.
REQ-006 The block SHALL have port o_ready, output, width 1: the block can accept an operand pair.
REQ-007 The block SHALL have port i_a, input, width WIDTH: operand A.
REQ-008 The block SHALL have port i_b, input, width WIDTH: operand B.
REQ-009 The block SHALL have port o_valid, output, width 1: result outputs are valid.
REQ-010 The block SHALL have port i_ready, input, width 1: the consumer accepts the result.
REQ-011 The block SHALL have port o_less_s, output, width 1: signed (two's complement) A < B.
REQ-012 The block SHALL have port o_less_u, output, width 1: unsigned A < B.
REQ-013 The block SHALL have port o_equal, output, width 1: A == B.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, SCAN, DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge with state IDLE and i_valid=1, the block SHALL register i_a and i_b, set the chunk index to NCHUNK-1, register sign_diff = i_a[WIDTH-1]^i_b[WIDTH-1], and go to SCAN.
REQ-017 In IDLE with i_valid=0, the state SHALL remain IDLE; i_a/i_b SHALL be ignored outside the accept edge.
REQ-018 SCAN, each edge: the block SHALL compare the registered chunks [idx*CHUNK +: CHUNK] of A and B, MSB chunk first.
REQ-019 If the SCAN chunks differ, the block SHALL latch o_equal=0 and o_less_u = (A chunk < B chunk, unsigned), then go to DONE (early termination).
REQ-020 If the SCAN chunks are equal and idx==0, the block SHALL latch o_equal=1 and o_less_u=0, then go to DONE.
REQ-021 If the SCAN chunks are equal and idx>0, idx SHALL decrement and the state SHALL remain SCAN.
REQ-022 o_less_s SHALL be latched with o_less_u: if sign_diff=1 it SHALL be the registered A[WIDTH-1], else it SHALL equal the o_less_u value; equal operands SHALL give o_less_s=0.
REQ-023 Latency: with k = number of chunks examined (1..NCHUNK), o_valid SHALL be 1 after the k-th edge following the accept edge.
REQ-024 Worst-case latency SHALL be NCHUNK edges; equal operands SHALL always take NCHUNK.
REQ-025 DONE: o_less_s/o_less_u/o_equal SHALL stay stable while o_valid=1 and i_ready=0.
REQ-026 DONE: on an edge with i_ready=1, the state SHALL go to IDLE; no operand accept SHALL occur on that edge, since o_ready=0 in DONE.
REQ-027 Result outputs SHALL hold their last latched values in IDLE and SCAN; they are meaningful only while o_valid=1.
REQ-028 i_ready SHALL be ignored outside DONE; i_valid SHALL be ignored outside IDLE.
REQ-029 Throughput SHALL be at most one result per k+2 cycles; no pipelining of multiple pairs is required.

Reset
REQ-030 On an edge with i_reset=1, from any state including mid-SCAN, the state SHALL become IDLE and idx SHALL become 0.
REQ-031 On that reset edge, o_less_s, o_less_u and o_equal SHALL become 0 and the registered operands SHALL be cleared to 0.
REQ-032 After reset, o_ready SHALL be 1 and o_valid SHALL be 0 in the following cycle.
REQ-033 i_reset SHALL take priority over any simultaneous accept or handoff; an in-flight comparison SHALL be discarded and produce no o_valid.

Verification
REQ-034 WIDTH=32, CHUNK=8; A=0x12345678, B=0x12345678, i_ready=1 -> o_valid after 4th edge after accept; o_equal=1, o_less_u=0, o_less_s=0; IDLE next edge.
REQ-035 A=0x80000000, B=0x00000001 -> o_valid after 1st edge (k=1); o_less_s=1, o_less_u=0, o_equal=0.
REQ-036 A=0x00000005, B=0x00000007 -> k=4; o_less_u=1, o_less_s=1, o_equal=0. A=0x00FF0000, B=0x00FE0000 -> k=2; all three outputs 0.
REQ-037 Backpressure: hold i_ready=0 for 3 cycles in DONE while driving i_valid=1 with new operands -> outputs unchanged, o_ready=0, no new accept; i_ready=1 -> IDLE, then new pair accepted.
REQ-038 Assert i_reset during SCAN (after 2nd edge of A=B=0xAAAAAAAA) -> next cycle o_ready=1, o_valid=0, all result outputs 0; o_valid never asserts for that pair.
REQ-039 WIDTH=16, CHUNK=4; A=0xFFFF, B=0x0001 -> k=1; o_less_s=1, o_less_u=0, o_equal=0.
